wave_gen_param: RTL
===================

# wave_gen_param

Parametrised multi-mode waveform generator: the next generation of the 5-bit up/down triangle generator. It adds configurable width, amplitude bounds, step size, four waveform modes, enable gating and an event strobe. It is a free-running source driven by a configuration/control front end. Its reset configuration reproduces the classic 0→max→0 triangle, so existing users can drop it in with default parameters.

## Interface
- `WIDTH`, default 5: wave/bounds/step width, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; low = hold all state.
- `cfg_load`  in  1  latch `mode`/`step`/`lo`/`hi` and restart waveform.
- `mode`  in  2  00 triangle, 01 saw-up, 10 saw-down, 11 square.
- `step`  in  WIDTH  increment per enabled cycle; half-period length in cycles in square mode.
- `lo`  in  WIDTH  lower bound (inclusive).
- `hi`  in  WIDTH  upper bound (inclusive).
- `wave`  out  WIDTH  registered waveform sample.
- `dir`  out  1  triangle direction: 0 up, 1 down; 0 in other modes.
- `evt`  out  1  one-cycle strobe on turn, wrap or toggle.
- `cfg_err`  out  1  latched configuration invalid.

## Operation
- Reset values:
  - Config registers: mode=00, step=1, lo=0, hi=2^WIDTH-1.
  - Outputs: wave=0, dir=0, evt=0, cfg_err=0.
  - Square counter cnt=0.
- Priority per edge: cfg_load > cfg_err hold > en > hold.
- cfg_load=1 behaviour:
  - Latch all four config inputs.
  - Set wave=lo (new value), dir=0, cnt=0, evt=0.
  - Set cfg_err=(lo≥hi)|(step==0).
  - en is ignored that cycle.
- cfg_err=1: wave holds at lo, evt=0. The block stays in this state until a valid cfg_load.
- en=0: wave, dir, cnt hold; evt=0.
- All comparisons use WIDTH+1-bit arithmetic; no internal overflow is permitted.
- Triangle mode:
  - dir=0: if wave+step ≥ hi, then wave=hi, dir=1, evt=1. Otherwise wave+=step.
  - dir=1: if wave ≤ lo+step, then wave=lo, dir=0, evt=1. Otherwise wave-=step.
  - step ≥ hi-lo gives lo/hi alternation every enabled cycle, with evt every cycle.
- Saw-up mode: if wave+step > hi, then wave=lo, evt=1. Otherwise wave+=step.
- Saw-down mode: if wave < lo+step, then wave=hi, evt=1. Otherwise wave-=step.
- Square mode:
  - When cnt==step-1: cnt=0, wave toggles lo↔hi, evt=1.
  - Otherwise cnt+=1.
  - Each level lasts step enabled cycles.
- The mode input only takes effect via cfg_load. Changing `mode`/`step`/`lo`/`hi` without cfg_load has no effect.

## Timing
- All outputs are registered; no combinational input→output path.
- Latency: cfg_load at edge N → wave=lo visible after edge N.
  - The first advance occurs at edge N+1 if en=1.
- evt is asserted in the same cycle wave first shows the turn/wrap/toggle value, for exactly one cycle per event.
- Asynchronous reset mid-waveform: all registers return to reset values immediately.
  - Generation resumes at the first edge after deassertion with en=1.
- Triangle period with step=1: 2·(hi-lo) enabled cycles.
- Saw period with step=1: hi-lo+1 enabled cycles.
- Square period: 2·step enabled cycles.

## Test plan
- **Default triangle:** reset, en=1, WIDTH=5 → wave 0,1,…,31,30,…,0,1.
  - evt when wave=31 and when wave=0 (not at reset).
  - dir=1 from the 31 sample through the sample before 0.
  - Period 62.
- **Saw-up clamp:** cfg_load mode=01, lo=4, hi=10, step=3 → wave 4,7,10,4,7,10; evt on each 4 after the first.
- **Saw-down and odd-step triangle:**
  - mode=10, lo=2, hi=9, step=2 → 2,9,7,5,3,9; evt on each 9.
  - mode=00, same bounds, step=4 → 2,6,9,5,2,6; evt at 9 and 2.
- **Square:** mode=11, lo=1, hi=20, step=3 → 1,1,1,20,20,20,1; evt on each level change.
- **Enable and error:**
  - en low for 5 cycles mid-ramp → wave/dir frozen, evt=0.
  - cfg_load with lo=8, hi=8 → cfg_err=1, wave=8 held regardless of en.
  - Valid cfg_load clears cfg_err.
- **Reset mid-operation:** assert rst_n=0 while wave=17, dir=1 → wave=0, dir=0, evt=0 immediately without a clock edge; config returns to default triangle.

Source files
------------

// File: rtl/wave_gen_param.sv
// Parametrised multi-mode waveform generator: triangle, saw-up, saw-down and square
// between configurable bounds, with enable gating, event strobe and config error latch.
module wave_gen_param #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] wave,
    output logic             dir,
    output logic             evt,
    output logic             cfg_err
);

    localparam int unsigned XW = WIDTH + 1;

    localparam logic [1:0] MODE_TRI  = 2'b00;
    localparam logic [1:0] MODE_SAWU = 2'b01;
    localparam logic [1:0] MODE_SAWD = 2'b10;
    localparam logic [1:0] MODE_SQR  = 2'b11;

    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] wave_d;
    logic             dir_d;
    logic             evt_d;
    logic             err_d;

    // Widened operands so bound checks can never wrap
    logic [XW-1:0] wave_plus_step;
    logic [XW-1:0] lo_plus_step;
    logic [XW-1:0] hi_x;
    logic [XW-1:0] wave_x;
    logic          cnt_last;

    assign wave_x         = XW'(wave);
    assign hi_x           = XW'(hi_q);
    assign wave_plus_step = wave_x + XW'(step_q);
    assign lo_plus_step   = XW'(lo_q) + XW'(step_q);
    assign cnt_last       = (XW'(cnt_q) + XW'(1)) == XW'(step_q);

    // Next-state logic: cfg_load > error hold > enabled advance > hold
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        cnt_d  = cnt_q;
        wave_d = wave;
        dir_d  = dir;
        evt_d  = 1'b0;
        err_d  = cfg_err;

        if (cfg_load) begin
            mode_d = mode;
            step_d = step;
            lo_d   = lo;
            hi_d   = hi;
            wave_d = lo;
            dir_d  = 1'b0;
            cnt_d  = '0;
            err_d  = (lo >= hi) || (step == '0);
        end else if (cfg_err) begin
            wave_d = lo_q;
        end else if (en) begin
            case (mode_q)
                MODE_TRI: begin
                    if (!dir) begin
                        if (wave_plus_step >= hi_x) begin
                            wave_d = hi_q;
                            dir_d  = 1'b1;
                            evt_d  = 1'b1;
                        end else begin
                            wave_d = WIDTH'(wave_plus_step);
                        end
                    end else begin
                        if (wave_x <= lo_plus_step) begin
                            wave_d = lo_q;
                            dir_d  = 1'b0;
                            evt_d  = 1'b1;
                        end else begin
                            wave_d = wave - step_q;
                        end
                    end
                end
                MODE_SAWU: begin
                    if (wave_plus_step > hi_x) begin
                        wave_d = lo_q;
                        evt_d  = 1'b1;
                    end else begin
                        wave_d = WIDTH'(wave_plus_step);
                    end
                end
                MODE_SAWD: begin
                    if (wave_x < lo_plus_step) begin
                        wave_d = hi_q;
                        evt_d  = 1'b1;
                    end else begin
                        wave_d = wave - step_q;
                    end
                end
                MODE_SQR: begin
                    if (cnt_last) begin
                        cnt_d  = '0;
                        wave_d = (wave == lo_q) ? hi_q : lo_q;
                        evt_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    wave_d = wave;
                end
            endcase
        end
    end

    // State and output registers; reset reproduces the classic 0..max triangle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_TRI;
            step_q  <= WIDTH'(1);
            lo_q    <= '0;
            hi_q    <= '1;
            cnt_q   <= '0;
            wave    <= '0;
            dir     <= 1'b0;
            evt     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            wave    <= wave_d;
            dir     <= dir_d;
            evt     <= evt_d;
            cfg_err <= err_d;
        end
    end

endmodule
